boot_controller: RTL

Sequences program load at power-up and on reload. Assembles the UART receiver's byte stream into 32-bit big-endian words and writes them through the instruction-memory write port. Computes the entry PC from the end-of-data marker and releases the CPU into run mode; a CPU halt returns the block to idle, ready for the next program. Sits between the UART receiver, instruction memory and the core's run/PC-init inputs.

---
 rtl/boot_pkg.sv | 21 ++
 rtl/word_assembler.sv | 33 +++
 rtl/boot_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM states, end-of-data marker
// and LED bit positions.
package boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_DONE,
        S_RUN,
        S_ERROR
    } boot_state_t;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

    localparam int LED_LOADING   = 0;
    localparam int LED_RUN       = 1;
    localparam int LED_ERROR     = 2;
    localparam int LED_COUNT_LSB = 3;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; word/word_valid are presented
// combinationally in the cycle the fourth byte arrives.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [31:0] shift;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= 2'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid) begin
            shift <= {shift[23:0], byte_data};
        end
    end

    assign word       = {shift[23:0], byte_data};
    assign word_valid = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/boot_controller.sv
// Program loader: header word gives the payload length, payload words go to
// instruction memory, the first all-ones word sets the entry PC, then the core runs.
module boot_controller
    import boot_pkg::*;
#(
    parameter int MEM_INST_SIZE  = 1024,
    parameter int ADDR_W         = $clog2(MEM_INST_SIZE),
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              CLK,
    input  logic              INITIALIZE,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              start,
    input  logic              cpu_halt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [31:0]       pc_init,
    output logic              cpu_run,
    output logic              loading,
    output logic              load_error,
    output logic [7:0]        LED
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ONE_C = 1;
    localparam logic [ADDR_W:0]   ONE_A = 1;

    boot_state_t       state;
    boot_state_t       next_state;
    logic              byte_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic              load_start;
    logic              header_bad;
    logic              is_last;
    logic              timer_active;
    logic              timeout_hit;
    logic              marker_seen;
    logic              got_byte;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   last_idx;
    logic [CNT_W-1:0]  idle_cnt;

    assign byte_valid   = rx_valid && (state == S_HDR || state == S_LOAD);
    assign load_start   = start && (state == S_IDLE || state == S_ERROR);
    assign header_bad   = (word == 32'd0) || (word > 32'(MEM_INST_SIZE));
    assign is_last      = (word_cnt == last_idx);
    // The stall timer only arms once the first header byte of this load has arrived.
    assign timer_active = (state == S_LOAD) || (state == S_HDR && got_byte);
    assign timeout_hit  = timer_active && !rx_valid && (idle_cnt == TIMEOUT_LAST);

    word_assembler u_asm (
        .clk        (CLK),
        .rst        (INITIALIZE),
        .clear      (load_start),
        .byte_valid (byte_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_HDR;
            S_HDR: begin
                if (word_valid)       next_state = header_bad ? S_ERROR : S_LOAD;
                else if (timeout_hit) next_state = S_ERROR;
            end
            S_LOAD: begin
                if (word_valid && is_last) next_state = S_DONE;
                else if (timeout_hit)      next_state = S_ERROR;
            end
            S_DONE:  next_state = S_RUN;
            S_RUN:   if (cpu_halt) next_state = S_IDLE;
            S_ERROR: if (start) next_state = S_HDR;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            pc_init     <= '0;
            marker_seen <= 1'b0;
            word_cnt    <= '0;
            last_idx    <= '0;
            idle_cnt    <= '0;
            got_byte    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (load_start) begin
                word_cnt    <= '0;
                pc_init     <= '0;
                marker_seen <= 1'b0;
                idle_cnt    <= '0;
                got_byte    <= 1'b0;
            end else if (byte_valid) begin
                idle_cnt <= '0;
                got_byte <= 1'b1;
            end else if (timer_active) begin
                idle_cnt <= idle_cnt + ONE_C;
            end
            if (state == S_HDR && word_valid) begin
                last_idx <= word[ADDR_W:0] - ONE_A;
            end
            // Only the first marker of a load sets the entry PC; later ones are plain data.
            if (state == S_LOAD && word_valid) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= word;
                word_cnt   <= word_cnt + ONE_A;
                if (word == END_MARKER && !marker_seen) begin
                    pc_init     <= 32'(word_cnt) + 32'd1;
                    marker_seen <= 1'b1;
                end
            end
        end
    end

    assign cpu_run    = (state == S_RUN);
    assign loading    = (state == S_LOAD);
    assign load_error = (state == S_ERROR);

    always_comb begin
        LED                   = '0;
        LED[LED_LOADING]      = loading;
        LED[LED_RUN]          = cpu_run;
        LED[LED_ERROR]        = load_error;
        LED[7:LED_COUNT_LSB]  = word_cnt[ADDR_W-1 -: 5];
    end

endmodule
